// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with a valid/ready load
// handshake, bit-rate enable, selectable bit order and synchronous flush.
// A new word can load in the same cycle the previous word's last bit is
// consumed, so back-to-back words stream with no idle bit between them.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  input  logic             flush,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             last
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               cnt_zero;
  logic               load;

  // Move the register one place toward the output end, filling with 0.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    if (LSB_FIRST) begin
      return v >> 1;
    end else begin
      return v << 1;
    end
  endfunction

  assign cnt_zero = (cnt_q == '0);

  // Handshake: ready while idle, or while the last bit is being consumed
  // (this is what lets consecutive words abut); flush always blocks a load.
  always_comb begin
    din_ready = (state_q == IDLE) ||
                ((state_q == SHIFT) && cnt_zero && shift_en && !flush);
    load      = din_valid && din_ready && !flush;
  end

  // Next-state logic: flush beats load, load beats shifting.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      state_d = SHIFT;
      shreg_d = din;
      cnt_d   = CNT_LAST;
    end else if ((state_q == SHIFT) && shift_en) begin
      if (!cnt_zero) begin
        shreg_d = shift_toward_out(shreg_q);
        cnt_d   = cnt_q - 1'b1;
      end else begin
        // Last bit consumed with no follow-on word.
        state_d = IDLE;
        shreg_d = '0;
      end
    end
  end

  // State registers; reset discards any partial word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    so       = IDLE_LEVEL;
    so_valid = 1'b0;
    busy     = 1'b0;
    last     = 1'b0;
    if (state_q == SHIFT) begin
      so       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
      so_valid = 1'b1;
      busy     = 1'b1;
      last     = cnt_zero;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one LSB-first and one MSB-first
// instance share the same stimulus; expected bits are hand-derived.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid, shift_en, flush;

  logic rdy_l, so_l, sov_l, busy_l, last_l;
  logic rdy_m, so_m, sov_m, busy_m, last_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .shift_en(shift_en), .flush(flush),
    .so(so_l), .so_valid(sov_l), .busy(busy_l), .last(last_l)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .shift_en(shift_en), .flush(flush),
    .so(so_m), .so_valid(sov_m), .busy(busy_m), .last(last_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checks.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic se, input logic fl);
    @(negedge clk);
    din_valid = v;
    din       = d;
    shift_en  = se;
    flush     = fl;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_so_l"},   so_l,   1'b0);
    check({tag, "_so_m"},   so_m,   1'b0);
    check({tag, "_sov"},    sov_l,  1'b0);
    check({tag, "_busy"},   busy_l, 1'b0);
    check({tag, "_rdy"},    rdy_l,  1'b1);
  endtask

  // Load one word with shift_en=1 and check all WIDTH bits plus return to idle.
  task automatic send_word(input string tag, input logic [W-1:0] d);
    drive(1'b1, d, 1'b1, 1'b0);
    check({tag, "_rdy_load"}, rdy_l, 1'b1);
    for (int i = 0; i < W; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check({tag, "_so_l"}, so_l,   d[i]);
      check({tag, "_so_m"}, so_m,   d[W-1-i]);
      check({tag, "_sov"},  sov_l,  1'b1);
      check({tag, "_last"}, last_l, (i == W-1));
      check({tag, "_lastm"}, last_m, (i == W-1));
      check({tag, "_rdy"},  rdy_l,  (i == W-1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    check_idle({tag, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w;
    int b;
    int j;

    rst_n = 1'b0; din = '0; din_valid = 1'b0; shift_en = 1'b0; flush = 1'b0;

    // Reset values
    drive(1'b0, '0, 1'b0, 1'b0);
    check_idle("reset");
    check("reset_last", last_l, 1'b0);
    check("reset_busy_m", busy_m, 1'b0);
    rst_n = 1'b1;

    // LSB-first B4 -> 0,0,1,0,1,1,0,1 ; MSB-first -> 1,0,1,1,0,1,0,0
    send_word("b4", 8'hB4);

    // Back-to-back FF then 00 with din_valid held
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    check("b2b_rdy0", rdy_l, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      drive((k <= 8), 8'h00, 1'b1, 1'b0);
      check("b2b_so_l", so_l,  (k <= 8));
      check("b2b_so_m", so_m,  (k <= 8));
      check("b2b_sov",  sov_l, 1'b1);
      check("b2b_rdy",  rdy_l, (k == 8 || k == 16));
      check("b2b_last", last_l, (k == 8 || k == 16));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    check_idle("b2b_end");

    // Rate enable: shift_en high every third cycle
    w = 8'hB4;
    drive(1'b1, w, 1'b1, 1'b0);
    b = 0;
    j = 0;
    while (b < W && j < 40) begin
      drive(1'b0, '0, (j % 3 == 0), 1'b0);
      check("rate_so_l", so_l, w[b]);
      check("rate_so_m", so_m, w[W-1-b]);
      check("rate_sov",  sov_l, 1'b1);
      check("rate_rdy",  rdy_l, (b == W-1) && shift_en);
      if (shift_en) b++;
      j++;
    end
    check("rate_bits_done", b, W);
    drive(1'b0, '0, 1'b0, 1'b0);
    check_idle("rate_end");

    // Flush at bit 3 with a competing 0F offered the same cycle
    w = 8'hB4;
    drive(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("fl_so_l", so_l, w[i]);
    end
    drive(1'b1, 8'h0F, 1'b1, 1'b1);
    check("fl_bit3", so_l, w[3]);
    check("fl_rdy",  rdy_l, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check_idle("fl_after");
    check("fl_sov_m", sov_m, 1'b0);

    // Flush in IDLE blocks that cycle's load
    drive(1'b1, 8'h0F, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("fl_idle_sov", sov_l, 1'b0);

    // 0F: LSB 1,1,1,1,0,0,0,0 ; MSB 0,0,0,0,1,1,1,1
    send_word("0f", 8'h0F);

    // Async reset mid-word during bit 5
    w = 8'hB4;
    drive(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("ar_so_l", so_l, w[i]);
    end
    check("ar_busy_pre", busy_l, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_idle("ar_now");
    check("ar_last", last_l, 1'b0);
    check("ar_busy_m", busy_m, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    check_idle("ar_rel");
    send_word("ar_new", 8'hB4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
